// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies and op predicates.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Multi-cycle ops that occupy the unit; accumulate ops exist only in the MADD build.
    function automatic logic is_start_op(input logic [3:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product, quotient/remainder and (with MDU_MADD_EN) accumulate.
// wr_en is low when the result must not reach HI/LO (divide by zero, no-op).
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [31:0] base_hi,
    input  logic [31:0] base_lo,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr_en
);

    logic        sgn;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
    logic        b_nz;

    always_comb begin
        sgn = (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);

        // Extending to 64 bits first lets one multiplier serve signed and unsigned forms.
        a_ext = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = a_ext * b_ext;

        // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
        a_mag   = (sgn && a[31]) ? -a : a;
        b_mag   = (sgn && b[31]) ? -b : b;
        b_nz    = |b;
        divisor = b_nz ? b_mag : 32'd1;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
        rem     = (sgn && a[31]) ? -r_mag : r_mag;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi    = '0;
        lo    = '0;
        wr_en = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                {hi, lo} = prod;
                wr_en    = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                hi    = rem;
                lo    = quot;
                wr_en = b_nz;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
                {hi, lo} = {base_hi, base_lo} + prod;
                wr_en    = 1'b1;
            end
            MDU_MSUB, MDU_MSUBU: begin
                {hi, lo} = {base_hi, base_lo} - prod;
                wr_en    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; busy counter and commit FSM wrap mdu_calc.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic        E_MDU_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_is_md,
    output logic        E_MDU_busy,
    output logic        MDU_stall,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               launch, commit;

    logic [3:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        calc_hi, calc_lo;
    logic               calc_wr;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        launch  = 1'b0;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (E_MDU_start && is_start_op(E_MDU_op)) begin
                    launch  = 1'b1;
                    state_n = S_BUSY;
                    cnt_n   = is_div_op(E_MDU_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            S_BUSY: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= MDU_NONE;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (launch) begin
                op_q <= E_MDU_op;
                a_q  <= E_A;
                b_q  <= E_B;
            end
        end
    end

`ifdef MDU_MADD_EN
    // Accumulation base is HI/LO as committed at the launch edge.
    logic [31:0] base_hi_q, base_lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_hi_q <= '0;
            base_lo_q <= '0;
        end else if (launch) begin
            base_hi_q <= hi_q;
            base_lo_q <= lo_q;
        end
    end
`endif

    mdu_calc u_calc (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
`ifdef MDU_MADD_EN
        .base_hi (base_hi_q),
        .base_lo (base_lo_q),
`endif
        .hi      (calc_hi),
        .lo      (calc_lo),
        .wr_en   (calc_wr)
    );

    // mthi/mtlo are honoured only while idle; the hazard unit never lets them meet a busy unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (calc_wr) begin
                hi_q <= calc_hi;
                lo_q <= calc_lo;
            end
        end else if (state == S_IDLE) begin
            if (E_MDU_op == MDU_MTHI) hi_q <= E_A;
            if (E_MDU_op == MDU_MTLO) lo_q <= E_A;
        end
    end

    assign E_MDU_busy = (state == S_BUSY);
    assign MDU_stall  = D_is_md & (E_MDU_start | E_MDU_busy);
    assign E_MDU_out  = (E_MDU_op == MDU_MFHI) ? hi_q :
                        (E_MDU_op == MDU_MFLO) ? lo_q : 32'd0;
    assign HI_out     = hi_q;
    assign LO_out     = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table plus hand-written stall/reset/busy sequences.
// Honours MDU_MADD_EN to check either the accumulate ops or their no-op behaviour.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDU_op;
    logic        E_MDU_start;
    logic [31:0] E_A, E_B;
    logic        D_is_md;
    logic        E_MDU_busy, MDU_stall;
    logic [31:0] E_MDU_out, HI_out, LO_out;

    int n_total  = 0;
    int n_passed = 0;

    mdu_unit dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDU_op    (E_MDU_op),
        .E_MDU_start (E_MDU_start),
        .E_A         (E_A),
        .E_B         (E_B),
        .D_is_md     (D_is_md),
        .E_MDU_busy  (E_MDU_busy),
        .MDU_stall   (MDU_stall),
        .E_MDU_out   (E_MDU_out),
        .HI_out      (HI_out),
        .LO_out      (LO_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] pre_hi, pre_lo;
        int          cycles;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_passed++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        E_MDU_op    = MDU_NONE;
        E_MDU_start = 1'b0;
        E_A         = '0;
        E_B         = '0;
    endtask

    task automatic preset(input logic [31:0] hi, input logic [31:0] lo);
        E_MDU_op = MDU_MTHI; E_A = hi; next_cycle();
        E_MDU_op = MDU_MTLO; E_A = lo; next_cycle();
        idle_inputs();
    endtask

    // Launch in the current cycle, check busy low then high for `cycles` cycles; returns in cycle N+1.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles);
        E_MDU_op = op; E_MDU_start = 1'b1; E_A = a; E_B = b;
        #2 check({name, " busy@launch"}, 32'(E_MDU_busy), 32'd0);
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= cycles; c++) begin
            #2 check($sformatf("%s busy@c%0d", name, c), 32'(E_MDU_busy), 32'd1);
            next_cycle();
        end
    endtask

    initial begin
        vecs[0] = '{"mult",     MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hDEAD, 32'hBEEF, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"multu",    MDU_MULTU, 32'hFFFF_FFFE, 32'd3,         32'hDEAD, 32'hBEEF, 5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{"div",      MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hDEAD, 32'hBEEF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_by0", MDU_DIVU,  32'd7,         32'd0,         32'hAAAA_0000, 32'h0000_5555, 10, 32'hAAAA_0000, 32'h0000_5555};
        vecs[4] = '{"div_ovf",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD, 32'hBEEF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"divu",     MDU_DIVU,  32'hFFFF_FFF9, 32'd2,         32'hDEAD, 32'hBEEF, 10, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[6] = '{"div_negb", MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'hDEAD, 32'hBEEF, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{"mult_min", MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'hDEAD, 32'hBEEF, 5,  32'h4000_0000, 32'h0000_0000};

        idle_inputs();
        D_is_md = 1'b0;
        reset   = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #2;
        check("reset busy",  32'(E_MDU_busy), 32'd0);
        check("reset stall", 32'(MDU_stall),  32'd0);
        check("reset hi",    HI_out,          32'd0);
        check("reset lo",    LO_out,          32'd0);
        check("reset out",   E_MDU_out,       32'd0);
        next_cycle();

        foreach (vecs[i]) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles);
            E_MDU_op = MDU_MFHI;
            #2;
            check({vecs[i].name, " busy done"}, 32'(E_MDU_busy), 32'd0);
            check({vecs[i].name, " hi"},        HI_out,          vecs[i].exp_hi);
            check({vecs[i].name, " lo"},        LO_out,          vecs[i].exp_lo);
            check({vecs[i].name, " mfhi"},      E_MDU_out,       vecs[i].exp_hi);
            E_MDU_op = MDU_MFLO;
            #1 check({vecs[i].name, " mflo"},   E_MDU_out,       vecs[i].exp_lo);
            next_cycle();
            idle_inputs();
        end

        // Stall with an HI/LO instruction waiting in D, then the mflo sees the new LO.
        D_is_md = 1'b1;
        E_MDU_op = MDU_MULT; E_MDU_start = 1'b1; E_A = 32'd5; E_B = 32'd7;
        #2 check("stall launch", 32'(MDU_stall), 32'd1);
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            #2 check($sformatf("stall c%0d", c), 32'(MDU_stall), 32'd1);
            next_cycle();
        end
        E_MDU_op = MDU_MFLO;
        #2;
        check("stall released", 32'(MDU_stall), 32'd0);
        check("mflo after mult", E_MDU_out,     32'd35);
        next_cycle();
        idle_inputs();

        // Non-MD instruction in D is never stalled.
        D_is_md = 1'b0;
        E_MDU_op = MDU_MULT; E_MDU_start = 1'b1; E_A = 32'd2; E_B = 32'd3;
        #2 check("nostall launch", 32'(MDU_stall), 32'd0);
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            #2 check($sformatf("nostall c%0d", c), 32'(MDU_stall), 32'd0);
            next_cycle();
        end
        #2 check("nostall lo", LO_out, 32'd6);

        // mthi then mfhi; LO is untouched.
        E_MDU_op = MDU_MTHI; E_A = 32'h1234_5678;
        next_cycle();
        E_MDU_op = MDU_MFHI; E_A = 32'd0;
        #2 check("mfhi after mthi", E_MDU_out, 32'h1234_5678);
        next_cycle();
        E_MDU_op = MDU_MFLO;
        #2 check("mflo unchanged", E_MDU_out, 32'd6);
        next_cycle();
        idle_inputs();

        // Stray start while busy is ignored: original mult finishes on time with its own result.
        E_MDU_op = MDU_MULT; E_MDU_start = 1'b1; E_A = 32'd4; E_B = 32'd9;
        next_cycle();
        idle_inputs();
        next_cycle();
        E_MDU_op = MDU_DIV; E_MDU_start = 1'b1; E_A = 32'd100; E_B = 32'd7;
        next_cycle();
        idle_inputs();
        for (int c = 3; c <= 5; c++) begin
            #2 check($sformatf("ignore busy c%0d", c), 32'(E_MDU_busy), 32'd1);
            next_cycle();
        end
        #2;
        check("ignore busy end", 32'(E_MDU_busy), 32'd0);
        check("ignore lo",       LO_out,          32'd36);
        check("ignore hi",       HI_out,          32'd0);
        repeat (12) next_cycle();
        #2;
        check("ignore no late commit lo", LO_out, 32'd36);
        check("ignore no late busy", 32'(E_MDU_busy), 32'd0);
        next_cycle();

        // Reset in cycle 3 of a div clears everything and nothing commits afterwards.
        preset(32'h11, 32'h22);
        E_MDU_op = MDU_DIV; E_MDU_start = 1'b1; E_A = 32'd100; E_B = 32'd7;
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        check("midreset busy", 32'(E_MDU_busy), 32'd0);
        check("midreset hi",   HI_out,          32'd0);
        check("midreset lo",   LO_out,          32'd0);
        repeat (12) next_cycle();
        #2;
        check("midreset later hi",   HI_out,          32'd0);
        check("midreset later lo",   LO_out,          32'd0);
        check("midreset later busy", 32'(E_MDU_busy), 32'd0);
        next_cycle();

        preset(32'h0, 32'h1);
`ifdef MDU_MADD_EN
        run_op("madd", MDU_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        #2;
        check("madd hi", HI_out, 32'd0);
        check("madd lo", LO_out, 32'd2);
        next_cycle();
        run_op("msubu", MDU_MSUBU, 32'd1, 32'd3, 5);
        #2;
        check("msubu hi", HI_out, 32'hFFFF_FFFF);
        check("msubu lo", LO_out, 32'hFFFF_FFFF);
`else
        E_MDU_op = MDU_MADD; E_MDU_start = 1'b1; E_A = 32'hFFFF_FFFF; E_B = 32'hFFFF_FFFF;
        next_cycle();
        idle_inputs();
        #2 check("madd off busy", 32'(E_MDU_busy), 32'd0);
        repeat (6) next_cycle();
        #2;
        check("madd off hi", HI_out, 32'd0);
        check("madd off lo", LO_out, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
